// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency ALU.
// One transaction in flight: IDLE grants, EXEC waits ALU_LAT cycles, RESP holds the result.
module alu_arbiter #(
    parameter int unsigned ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [7:0]  req_op,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_flags,
    output logic [31:0] alu_a_operand,
    output logic [31:0] alu_b_operand,
    output logic [3:0]  alu_operation,
    input  logic [31:0] alu_result,
    input  logic        alu_exception,
    input  logic        alu_overflow,
    input  logic        alu_underflow,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_last_grant;
    logic        r_grantee;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_op;
    logic [31:0] r_result;
    logic [2:0]  r_flags;
    logic        w_sel;
    logic        w_accept;

    always_comb begin
        w_next    = r_state;
        w_sel     = 1'b0;
        w_accept  = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        case (r_state)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    // On a tie the requester not served last wins.
                    case (req_valid)
                        2'b01:   w_sel = 1'b0;
                        2'b10:   w_sel = 1'b1;
                        default: w_sel = ~r_last_grant;
                    endcase
                    req_ready[w_sel] = 1'b1;
                    w_accept         = 1'b1;
                    w_next           = EXEC;
                end
            end
            EXEC: begin
                if (r_cnt == 4'd0) w_next = RESP;
            end
            RESP: begin
                rsp_valid[r_grantee] = 1'b1;
                if (rsp_ready[r_grantee]) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_grantee    <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_result     <= '0;
            r_flags      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a          <= w_sel ? req_a[63:32] : req_a[31:0];
                r_b          <= w_sel ? req_b[63:32] : req_b[31:0];
                r_op         <= w_sel ? req_op[7:4]  : req_op[3:0];
                r_grantee    <= w_sel;
                r_last_grant <= w_sel;
                r_cnt        <= CNT_INIT;
            end else if (r_state == EXEC) begin
                if (r_cnt == 4'd0) begin
                    r_result <= alu_result;
                    r_flags  <= {alu_exception, alu_overflow, alu_underflow};
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

    assign alu_a_operand = r_a;
    assign alu_b_operand = r_b;
    assign alu_operation = r_op;
    assign rsp_result    = r_result;
    assign rsp_flags     = r_flags;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a transaction-level reference model,
// plus latency measurement on ALU_LAT=1 and ALU_LAT=15 instances.
module tb_alu_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, rsp_ready, req_ready, rsp_valid;
    logic [63:0] req_a, req_b;
    logic [7:0]  req_op;
    logic [31:0] rsp_result, alu_a_operand, alu_b_operand, alu_result;
    logic [2:0]  rsp_flags;
    logic [3:0]  alu_operation;
    logic        alu_exception, alu_overflow, alu_underflow, busy;

    logic        ovr_en;
    logic [31:0] ovr_result;
    logic [2:0]  ovr_flags;

    logic [1:0]  p_valid, p_rsp_ready;
    logic [1:0]  p1_req_ready, p1_rsp_valid, p15_req_ready, p15_rsp_valid;
    logic [31:0] p1_result, p1_a, p1_b, p15_result, p15_a, p15_b;
    logic [2:0]  p1_flags, p15_flags;
    logic [3:0]  p1_op, p15_op;
    logic        p1_busy, p15_busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        g;
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_arbiter #(.ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a_operand(alu_a_operand), .alu_b_operand(alu_b_operand),
        .alu_operation(alu_operation), .alu_result(alu_result),
        .alu_exception(alu_exception), .alu_overflow(alu_overflow),
        .alu_underflow(alu_underflow), .busy(busy)
    );

    alu_arbiter #(.ALU_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(p_valid), .req_ready(p1_req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(p1_rsp_valid),
        .rsp_ready(p_rsp_ready), .rsp_result(p1_result), .rsp_flags(p1_flags),
        .alu_a_operand(p1_a), .alu_b_operand(p1_b), .alu_operation(p1_op),
        .alu_result(32'h0), .alu_exception(1'b0), .alu_overflow(1'b0),
        .alu_underflow(1'b0), .busy(p1_busy)
    );

    alu_arbiter #(.ALU_LAT(15)) u_lat15 (
        .clk(clk), .rst_n(rst_n), .req_valid(p_valid), .req_ready(p15_req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(p15_rsp_valid),
        .rsp_ready(p_rsp_ready), .rsp_result(p15_result), .rsp_flags(p15_flags),
        .alu_a_operand(p15_a), .alu_b_operand(p15_b), .alu_operation(p15_op),
        .alu_result(32'h0), .alu_exception(1'b0), .alu_overflow(1'b0),
        .alu_underflow(1'b0), .busy(p15_busy)
    );

    function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        logic [31:0] r;
        case (op)
            4'h0:    r = a + b;
            4'h1:    r = a - b;
            4'h2:    r = a & b;
            4'h3:    r = a | b;
            4'h4:    r = a ^ b;
            default: r = a + {28'h0, op};
        endcase
        return {op == 4'hF, op == 4'hE, op == 4'hD, r};
    endfunction

    // Behavioural ALU seen by the DUT; override lets directed tests force exact values.
    always_comb begin
        if (ovr_en)
            {alu_exception, alu_overflow, alu_underflow, alu_result} = {ovr_flags, ovr_result};
        else
            {alu_exception, alu_overflow, alu_underflow, alu_result} =
                alu_fn(alu_a_operand, alu_b_operand, alu_operation);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rr_pick(input logic [1:0] v, input logic last);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
        return ~last;
    endfunction

    // Transaction-level model: in flight or not, who owns it, and how long ago it started.
    logic       m_inflight = 1'b0;
    logic       m_last = 1'b1;
    logic       m_g = 1'b0;
    int         m_age = 0;
    logic       m_was;
    logic       m_pick;
    logic [1:0] m_er;
    logic [1:0] m_erv;
    exp_t       m_e;
    logic [34:0] m_fr;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs",
                  {48'h0, req_ready, rsp_valid, busy, rsp_flags, alu_operation} |
                  {32'h0, rsp_result} | {32'h0, alu_a_operand} | {32'h0, alu_b_operand}, 64'h0);
            m_inflight = 1'b0;
            m_last     = 1'b1;
            m_g        = 1'b0;
            m_age      = 0;
            exp_q.delete();
        end else begin
            m_was = m_inflight;
            if (m_inflight) m_age++;
            m_pick = rr_pick(req_valid, m_last);
            m_er   = (m_was || req_valid == 2'b00) ? 2'b00 : (m_pick ? 2'b10 : 2'b01);
            m_erv  = (m_was && m_age >= LAT + 1) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
            check("req_ready", {62'h0, req_ready}, {62'h0, m_er});
            check("busy", {63'h0, busy}, {63'h0, m_was});
            check("rsp_valid", {62'h0, rsp_valid}, {62'h0, m_erv});
            if (m_erv != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_nonempty", 64'h0, 64'h1);
                end else begin
                    check("rsp_result", {32'h0, rsp_result}, {32'h0, exp_q[0].res});
                    check("rsp_flags", {61'h0, rsp_flags}, {61'h0, exp_q[0].flg});
                    if (rsp_ready[m_g]) begin
                        void'(exp_q.pop_front());
                        m_inflight = 1'b0;
                    end
                end
            end
            if (!m_was && req_valid != 2'b00) begin
                m_fr = m_pick ? alu_fn(req_a[63:32], req_b[63:32], req_op[7:4])
                              : alu_fn(req_a[31:0], req_b[31:0], req_op[3:0]);
                m_e.g   = m_pick;
                m_e.res = ovr_en ? ovr_result : m_fr[31:0];
                m_e.flg = ovr_en ? ovr_flags : m_fr[34:32];
                exp_q.push_back(m_e);
                m_inflight = 1'b1;
                m_g        = m_pick;
                m_last     = m_pick;
                m_age      = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (!busy) break;
            step();
        end
        check("reaches_idle", {63'h0, busy}, 64'h0);
    endtask

    task automatic randomize_operands();
        req_a  = {$urandom, $urandom};
        req_b  = {$urandom, $urandom};
        req_op = 8'($urandom);
    endtask

    int a1, r1, a15, r15;

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
        ovr_en = 1'b0; ovr_result = '0; ovr_flags = '0; p_valid = '0; p_rsp_ready = 2'b11;
        step(); step();

        // Single operation issued in the very first cycle out of reset
        rst_n = 1'b1;
        ovr_en = 1'b1; ovr_result = 32'h40400000; ovr_flags = 3'b000;
        req_a = {32'h0, 32'h3F800000}; req_b = {32'h0, 32'h40000000}; req_op = 8'h00;
        req_valid = 2'b01; rsp_ready = 2'b01;
        step();
        req_valid = 2'b00;
        wait_idle();
        ovr_en = 1'b0;
        step();

        // Continuous tie: grants must alternate
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int i = 0; i < 40; i++) begin
            randomize_operands();
            step();
        end
        req_valid = 2'b00;
        wait_idle();
        step();

        // Backpressure in RESP while the other requester waits
        randomize_operands();
        req_valid = 2'b01; rsp_ready = 2'b00;
        step();
        req_valid = 2'b10;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid != 2'b00) break;
            step();
        end
        check("bp_rsp_seen", {62'h0, rsp_valid}, 64'h1);
        for (int i = 0; i < 5; i++) step();
        req_valid = 2'b00; rsp_ready = 2'b01;
        wait_idle();
        step();

        // Overflow flag passes through untouched
        ovr_en = 1'b1; ovr_result = 32'h7F800000; ovr_flags = 3'b010;
        req_valid = 2'b10; rsp_ready = 2'b10;
        step();
        req_valid = 2'b00;
        wait_idle();
        ovr_en = 1'b0;
        step();

        // Reset one cycle after acceptance abandons the transaction
        randomize_operands();
        req_valid = 2'b11; rsp_ready = 2'b11;
        step();
        req_valid = 2'b00;
        step();
        rst_n = 1'b0;
        #1;
        check("reset_immediate", {59'h0, busy, rsp_valid, req_ready}, 64'h0);
        step(); step();
        req_valid = 2'b11;
        rst_n = 1'b1;
        #1;
        check("post_reset_tie_grant", {62'h0, req_ready}, 64'h1);
        step();
        req_valid = 2'b00;
        wait_idle();
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomize_operands();
            req_valid = 2'($urandom);
            rsp_ready = 2'($urandom);
            step();
        end
        req_valid = 2'b00; rsp_ready = 2'b11;
        wait_idle();
        step();

        // Latency on the ALU_LAT=1 and ALU_LAT=15 instances
        a1 = -1; r1 = -1; a15 = -1; r15 = -1;
        p_valid = 2'b01;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (p1_req_ready[0] && a1 < 0) a1 = c;
            if (p1_rsp_valid[0] && r1 < 0) r1 = c;
            if (p15_req_ready[0] && a15 < 0) a15 = c;
            if (p15_rsp_valid[0] && r15 < 0) r15 = c;
            @(posedge clk);
            #1;
            if (a1 >= 0 && a15 >= 0) p_valid = 2'b00;
        end
        check("lat1_accept_seen", {63'h0, a1 >= 0}, 64'h1);
        check("lat1_cycles", 64'(r1 - a1), 64'd2);
        check("lat15_cycles", 64'(r15 - a15), 64'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
